// File: rtl/dmem_port_if.sv
// Purpose: request/response bundle between the datapath memory stage and dmem_port.
// Latency: none (wires only).
// Backpressure: the requester must watch busy; a req raised while busy=1 is dropped.
// Signals: req/we/addr/wdata driven by the master (datapath).
//          rdata/ack/busy/err driven by the slave (memory responder).
interface dmem_port_if #(
  parameter int n = 32
);
  logic         req;
  logic         we;
  logic [n-1:0] addr;
  logic [n-1:0] wdata;
  logic [n-1:0] rdata;
  logic         ack;
  logic         busy;
  logic         err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy, err
  );
endinterface

// File: rtl/dmem_port.sv
// Purpose: word-addressed data memory with programmable wait states, one access in flight.
// Latency: ack is high in the (WAIT_CYCLES+1)-th cycle after the accept edge.
// Backpressure: busy=1 from accept through the ack cycle; req is ignored, not queued, while busy.
// Ports: clk (rising edge), reset (async, active-low), bus (dmem_port_if.slave:
//        req/we/addr/wdata in, rdata/ack/busy/err out).
// Option: define DMEM_ALIGN_CHECK_EN to flag addr[1:0]!=0 accesses with err and suppress them.
module dmem_port #(
  parameter int n           = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  dmem_port_if.slave  bus
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [n-1:0]   wdata_q, wdata_d;
  logic [n-1:0]   rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           enter_resp;
  logic           misalign;

  logic [n-1:0]   mem [DEPTH];

  // With zero wait states RESP is entered on the accept edge itself, before
  // the captured copies exist, so the access uses the live inputs in IDLE.
  logic           from_idle;
  logic           acc_we;
  logic [IW-1:0]  acc_idx;
  logic [n-1:0]   acc_wdata;

  assign from_idle = (state_q == IDLE);
  assign acc_we    = from_idle ? bus.we             : we_q;
  assign acc_idx   = from_idle ? bus.addr[IW+1:2]   : idx_q;
  assign acc_wdata = from_idle ? bus.wdata          : wdata_q;

  // Address bits above the word index are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^bus.addr;

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] lsb_q, lsb_d;
  logic [1:0] acc_lsb;
  assign acc_lsb  = from_idle ? bus.addr[1:0] : lsb_q;
  assign misalign = (acc_lsb != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lsb_q <= 2'b00;
    else        lsb_q <= lsb_d;
  end

  always_comb begin
    lsb_d = lsb_q;
    if (from_idle && bus.req) lsb_d = bus.addr[1:0];
  end
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          idx_d   = bus.addr[IW+1:2];
          wdata_d = bus.wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <=1 rather than ==1 so a corrupted zero count cannot strand the FSM.
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          cnt_d      = 4'd0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rdata/err are loaded on RESP entry and cleared on the edge leaving RESP,
  // so they read 0 everywhere outside the ack cycle.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      rdata_d = (acc_we || misalign) ? '0 : mem[acc_idx];
      err_d   = misalign;
    end else if (state_q == RESP) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end

  // Storage is not reset; the reset qualifier keeps an access from committing
  // while reset is held with req high and zero wait states.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_we && !misalign)
      mem[acc_idx] <= acc_wdata;
  end

  assign bus.ack   = (state_q == RESP);
  assign bus.busy  = (state_q != IDLE);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_port.sv
// Purpose: self-checking bench for dmem_port; two instances (2 and 0 wait states)
// Latency: checks ack lands WAIT_CYCLES+1 cycles after accept against a memory-array model.
// Backpressure: checks dropped requests during busy and back-to-back throughput.
module tb_dmem_port;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk;
  logic reset;

  dmem_port_if #(.n(32)) b2 ();
  dmem_port_if #(.n(32)) b0 ();

  dmem_port #(.n(32), .DEPTH(64), .WAIT_CYCLES(2)) u2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  dmem_port #(.n(32), .DEPTH(64), .WAIT_CYCLES(0)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // d=0 selects the 2-wait instance, d=1 the 0-wait instance
  task automatic drive(input int d, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      b2.req = r; b2.we = w; b2.addr = a; b2.wdata = wd;
    end else begin
      b0.req = r; b0.we = w; b0.addr = a; b0.wdata = wd;
    end
  endtask

  task automatic peek(input int d, output logic [31:0] rd, output logic ak,
                      output logic bz, output logic er);
    if (d == 0) begin
      rd = b2.rdata; ak = b2.ack; bz = b2.busy; er = b2.err;
    end else begin
      rd = b0.rdata; ak = b0.ack; bz = b0.busy; er = b0.err;
    end
  endtask

  // One complete transaction, entered and left at a falling edge.
  task automatic xact(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
    logic [31:0] rd;
    logic        ak, bz, er;
    int          lat;
    int          exp_lat;
    exp_lat = (d == 0) ? 3 : 1;
    drive(d, 1'b1, w, a, wd);
    @(posedge clk);
    @(negedge clk);
    // inputs are don't-care after accept: scramble them
    drive(d, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    lat = 1;
    peek(d, rd, ak, bz, er);
    while (!ak && lat < 20) begin
      check({tag, ".busy_wait"}, 32'(bz), 32'd1);
      @(negedge clk);
      lat++;
      peek(d, rd, ak, bz, er);
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, 32'(er), 32'(exp_err));
    check({tag, ".busy_resp"}, 32'(bz), 32'd1);
    @(negedge clk);
    peek(d, rd, ak, bz, er);
    check({tag, ".ack_after"}, 32'(ak), 32'd0);
    check({tag, ".busy_after"}, 32'(bz), 32'd0);
    check({tag, ".rdata_after"}, rd, 32'd0);
  endtask

  logic [31:0] mdl [2][64];
  bit          vld [2][64];

  logic [31:0] rd, a, wd, exp_rd;
  logic        ak, bz, er, w, mis;
  int          d, idx, lsb;

  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) vld[i][j] = 1'b0;

    // reset, then idle
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 11; c++) begin
      for (int k = 0; k < 2; k++) begin
        peek(k, rd, ak, bz, er);
        check("idle.ack", 32'(ak), 32'd0);
        check("idle.busy", 32'(bz), 32'd0);
        check("idle.err", 32'(er), 32'd0);
        check("idle.rdata", rd, 32'd0);
      end
      @(negedge clk);
    end

    // store then load, 2 wait states
    xact(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, "w2.store");
    xact(0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, "w2.load");

    // zero wait states
    xact(1, 1'b1, 32'h0000_0014, 32'h1234_5678, 32'd0, 1'b0, "w0.store");
    xact(1, 1'b0, 32'h0000_0014, 32'd0, 32'h1234_5678, 1'b0, "w0.load");

    // continuous req: ack every second cycle
    drive(1, 1'b1, 1'b0, 32'h0000_0014, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      peek(1, rd, ak, bz, er);
      check("b2b.ack", 32'(ak), 32'(i % 2));
      if (ak) check("b2b.rdata", rd, 32'h1234_5678);
      if (i == 8) drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    @(negedge clk);

    // request raised while busy is dropped
    xact(0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'd0, 1'b0, "drop.pre");
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'hAAAA_AAAA);
    peek(0, rd, ak, bz, er);
    check("drop.ack1", 32'(ak), 32'd0);
    check("drop.busy1", 32'(bz), 32'd1);
    @(negedge clk);
    peek(0, rd, ak, bz, er);
    check("drop.ack2", 32'(ak), 32'd0);
    @(negedge clk);
    peek(0, rd, ak, bz, er);
    check("drop.ack3", 32'(ak), 32'd1);
    check("drop.rdata3", rd, 32'hDEAD_BEEF);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      peek(0, rd, ak, bz, er);
      check("drop.no_ack", 32'(ak), 32'd0);
      check("drop.no_busy", 32'(bz), 32'd0);
    end
    xact(0, 1'b0, 32'h0000_0020, 32'd0, 32'h0BAD_F00D, 1'b0, "drop.load");

    // reset during WAIT discards the store
    xact(0, 1'b1, 32'h0000_0008, 32'h0000_8888, 32'd0, 1'b0, "rst.pre");
    drive(0, 1'b1, 1'b1, 32'h0000_0008, 32'h5555_5555);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    peek(0, rd, ak, bz, er);
    check("rst.in_wait", 32'(bz), 32'd1);
    reset = 1'b0;
    #1;
    peek(0, rd, ak, bz, er);
    check("rst.busy", 32'(bz), 32'd0);
    check("rst.ack", 32'(ak), 32'd0);
    check("rst.rdata", rd, 32'd0);
    check("rst.err", 32'(er), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    xact(0, 1'b0, 32'h0000_0008, 32'd0, 32'h0000_8888, 1'b0, "rst.load");

    // alignment
    xact(0, 1'b1, 32'h0000_0004, 32'h1111_1111, 32'd0, 1'b0, "al.pre");
    xact(0, 1'b1, 32'h0000_0006, 32'hCAFE_0001, 32'd0, ALIGN, "al.store");
    xact(0, 1'b0, 32'h0000_0004, 32'd0, ALIGN ? 32'h1111_1111 : 32'hCAFE_0001,
         1'b0, "al.load");
    xact(0, 1'b0, 32'h0000_0006, 32'd0, ALIGN ? 32'd0 : 32'hCAFE_0001,
         ALIGN, "al.mis_load");

    // randomized traffic against an array model
    for (int t = 0; t < 80; t++) begin
      d   = $urandom_range(0, 1);
      idx = $urandom_range(0, 15);
      lsb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      w   = vld[d][idx] ? 1'($urandom_range(0, 1)) : 1'b1;
      a   = ($urandom & 32'hFFFF_FF00) | 32'(idx * 4) | 32'(lsb);
      wd  = $urandom;
      mis = ALIGN && (lsb != 0);
      exp_rd = (w || mis) ? 32'd0 : mdl[d][idx];
      xact(d, w, a, wd, exp_rd, mis, "rnd");
      if (w && !mis) begin
        mdl[d][idx] = wd;
        vld[d][idx] = 1'b1;
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        peek(d, rd, ak, bz, er);
        check("rnd.gap_ack", 32'(ak), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
